// File: rtl/track_search_ctrl_if.sv
// Handshake bundle between the tracking sequencer and its neighbours:
// key/debounce and frame timing in, search engine result in, overlay out.
interface track_search_ctrl_if #(
  parameter int COORD_W = 13
);
  logic               iSAVE_REQ;
  logic               iFRAME_START;
  logic               iSRCH_DONE;
  logic [COORD_W-1:0] iSRCH_X;
  logic [COORD_W-1:0] iSRCH_Y;
  logic               oSAVE_EN;
  logic               oSRCH_START;
  logic [COORD_W-1:0] oXresult;
  logic [COORD_W-1:0] oYresult;
  logic               oFinished;
  logic               oTIMEOUT;
  logic [2:0]         oSTATE;

  // Environment side: drives requests/results, observes the sequencer.
  modport master (
    output iSAVE_REQ, iFRAME_START, iSRCH_DONE, iSRCH_X, iSRCH_Y,
    input  oSAVE_EN, oSRCH_START, oXresult, oYresult, oFinished, oTIMEOUT, oSTATE
  );

  // Sequencer side.
  modport slave (
    input  iSAVE_REQ, iFRAME_START, iSRCH_DONE, iSRCH_X, iSRCH_Y,
    output oSAVE_EN, oSRCH_START, oXresult, oYresult, oFinished, oTIMEOUT, oSTATE
  );
endinterface

// File: rtl/track_search_ctrl.sv
// Frame-synchronous template-tracking sequencer: one template-save frame,
// then repeated search launches. Results are staged as "pending" and only
// committed to the overlay on a frame start so the marker never tears.
module track_search_ctrl #(
  parameter int COORD_W        = 13,
  parameter int MAX_X          = 8191,
  parameter int MAX_Y          = 8191,
  parameter int REFRESH_FRAMES = 4,
  parameter int TIMEOUT_FRAMES = 8
) (
  input  logic                iCLK,
  input  logic                iRST,
  track_search_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SAVE_WAIT = 3'd1,
    S_SAVE      = 3'd2,
    S_SRCH_WAIT = 3'd3,
    S_SEARCH    = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

  localparam logic [COORD_W-1:0] LP_MAX_X   = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] LP_MAX_Y   = COORD_W'(MAX_Y);
  localparam logic [7:0]         LP_REFRESH = 8'(REFRESH_FRAMES);
  localparam logic [7:0]         LP_TIMEOUT = 8'(TIMEOUT_FRAMES);

  state_t             r_state, w_state;
  logic [7:0]         r_cnt, w_cnt, w_cnt_inc;
  logic               r_pend, w_pend;
  logic [COORD_W-1:0] r_px, w_px, r_py, w_py;
  logic [COORD_W-1:0] r_x, w_x, r_y, w_y;
  logic [COORD_W-1:0] w_clip_x, w_clip_y;
  logic               r_save_en, w_save_en;
  logic               r_start, w_start, w_launch;
  logic               r_tmo, w_tmo;
  logic               r_fin, w_fin;
  logic               w_restart;

  assign w_clip_x  = (bus.iSRCH_X > LP_MAX_X) ? LP_MAX_X : bus.iSRCH_X;
  assign w_clip_y  = (bus.iSRCH_Y > LP_MAX_Y) ? LP_MAX_Y : bus.iSRCH_Y;
  assign w_cnt_inc = r_cnt + 8'd1;
  // A save request outside IDLE aborts everything in flight.
  assign w_restart = bus.iSAVE_REQ && (r_state != S_IDLE);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_pend    = r_pend;
    w_px      = r_px;
    w_py      = r_py;
    w_x       = r_x;
    w_y       = r_y;
    w_save_en = r_save_en;
    w_fin     = r_fin;
    w_tmo     = 1'b0;
    w_launch  = 1'b0;
    w_start   = 1'b0;
    if (w_restart) begin
      w_state   = S_SAVE_WAIT;
      w_save_en = 1'b0;
      w_fin     = 1'b0;
      w_pend    = 1'b0;
      w_cnt     = 8'd0;
    end else begin
      // Commit staged result on a frame boundary, whatever the state.
      if (bus.iFRAME_START && r_pend) begin
        w_x    = r_px;
        w_y    = r_py;
        w_fin  = 1'b1;
        w_pend = 1'b0;
      end
      case (r_state)
        S_IDLE:
          if (bus.iSAVE_REQ) w_state = S_SAVE_WAIT;
        S_SAVE_WAIT:
          if (bus.iFRAME_START) begin
            w_state   = S_SAVE;
            w_save_en = 1'b1;
          end
        S_SAVE:
          if (bus.iFRAME_START) begin
            w_state   = S_SRCH_WAIT;
            w_save_en = 1'b0;
          end
        S_SRCH_WAIT:
          if (bus.iFRAME_START) begin
            w_state  = S_SEARCH;
            w_launch = 1'b1;
            w_cnt    = 8'd0;
          end
        S_SEARCH:
          // Done wins over a coincident frame start: no count, no timeout.
          if (bus.iSRCH_DONE) begin
            w_px    = w_clip_x;
            w_py    = w_clip_y;
            w_pend  = 1'b1;
            w_cnt   = 8'd0;
            w_state = S_HOLD;
          end else if (bus.iFRAME_START) begin
            if (w_cnt_inc >= LP_TIMEOUT) begin
              w_tmo    = 1'b1;
              w_fin    = 1'b0;
              w_launch = 1'b1;
              w_cnt    = 8'd0;
            end else begin
              w_cnt = w_cnt_inc;
            end
          end
        S_HOLD:
          if (bus.iFRAME_START) begin
            if (w_cnt_inc >= LP_REFRESH) begin
              w_launch = 1'b1;
              w_cnt    = 8'd0;
              w_state  = S_SEARCH;
            end else begin
              w_cnt = w_cnt_inc;
            end
          end
        default: w_state = S_IDLE;
      endcase
    end
    // Launch is a strict single-cycle pulse even with back-to-back triggers.
    w_start = w_launch & ~r_start;
  end

  // State, counters, staged result and registered outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_pend    <= 1'b0;
      r_px      <= '0;
      r_py      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_save_en <= 1'b0;
      r_start   <= 1'b0;
      r_tmo     <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_pend    <= w_pend;
      r_px      <= w_px;
      r_py      <= w_py;
      r_x       <= w_x;
      r_y       <= w_y;
      r_save_en <= w_save_en;
      r_start   <= w_start;
      r_tmo     <= w_tmo;
      r_fin     <= w_fin;
    end
  end

  assign bus.oSAVE_EN    = r_save_en;
  assign bus.oSRCH_START = r_start;
  assign bus.oXresult    = r_x;
  assign bus.oYresult    = r_y;
  assign bus.oFinished   = r_fin;
  assign bus.oTIMEOUT    = r_tmo;
  assign bus.oSTATE      = r_state;

endmodule

// File: tb/tb_track_search_ctrl.sv
// Randomized scoreboard bench for track_search_ctrl. A planner lays out a
// whole run at frame granularity (frame starts, search results, restarts)
// and predicts every visible output event; a negedge monitor pops and
// compares whenever the outputs change or pulse.
module tb_track_search_ctrl;
  localparam int CW   = 13;
  localparam int MX   = 639;
  localparam int MY   = 479;
  localparam int REF  = 4;
  localparam int TMO  = 8;
  localparam int MAXC = 30000;

  typedef struct {
    int cyc; int st; bit sen; bit ss; bit tmo; int x; int y; bit fin;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  track_search_ctrl_if #(.COORD_W(CW)) bus ();

  track_search_ctrl #(
    .COORD_W(CW), .MAX_X(MX), .MAX_Y(MY),
    .REFRESH_FRAMES(REF), .TIMEOUT_FRAMES(TMO)
  ) dut (
    .iCLK(clk), .iRST(rst_n), .bus(bus.slave)
  );

  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_chk = 0, n_pass = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  // Planned stimulus, indexed by cycle.
  bit  fs_a[MAXC], dn_a[MAXC], sv_a[MAXC];
  int  dx_a[MAXC], dy_a[MAXC];
  int  t;
  // Expected visible outputs and the last snapshot pushed.
  int  cur_st = 0, cur_x = 0, cur_y = 0;
  bit  cur_sen = 0, cur_fin = 0;
  int  lp_st = 0, lp_x = 0, lp_y = 0;
  bit  lp_sen = 0, lp_fin = 0;

  task automatic check(string nm, int act, int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
  endtask

  function automatic string ev_s(ev_t e);
    return $sformatf("cyc=%0d st=%0d sen=%0d start=%0d tmo=%0d x=%0d y=%0d fin=%0d",
                     e.cyc, e.st, e.sen, e.ss, e.tmo, e.x, e.y, e.fin);
  endfunction

  function automatic bit ev_eq(ev_t a, ev_t b);
    return a.cyc == b.cyc && a.st == b.st && a.sen == b.sen && a.ss == b.ss &&
           a.tmo == b.tmo && a.x == b.x && a.y == b.y && a.fin == b.fin;
  endfunction

  function automatic int clampv(int v, int m);
    return (v > m) ? m : v;
  endfunction

  // Inputs applied in cycle c are visible at the outputs in cycle c+1.
  task automatic expect_at(int c, bit ss, bit tm);
    ev_t e;
    if (ss || tm || cur_st != lp_st || cur_sen != lp_sen || cur_x != lp_x ||
        cur_y != lp_y || cur_fin != lp_fin) begin
      e.cyc = c + 1; e.st = cur_st; e.sen = cur_sen; e.ss = ss; e.tmo = tm;
      e.x = cur_x; e.y = cur_y; e.fin = cur_fin;
      exp_q.push_back(e);
      lp_st = cur_st; lp_sen = cur_sen; lp_x = cur_x; lp_y = cur_y; lp_fin = cur_fin;
    end
  endtask

  task automatic plan_fs(output int c);
    t = t + int'($urandom_range(24, 8));
    c = t;
    fs_a[c] = 1'b1;
  endtask

  task automatic put_done(int c);
    dn_a[c] = 1'b1;
    dx_a[c] = ($urandom_range(2, 0) == 0) ? int'($urandom_range(8191, MX + 1)) : int'($urandom_range(MX, 0));
    dy_a[c] = ($urandom_range(2, 0) == 0) ? int'($urandom_range(8191, MY + 1)) : int'($urandom_range(MY, 0));
  endtask

  // Save request already placed: capture frame, then one idle frame, then launch.
  task automatic plan_save_seq();
    int c;
    plan_fs(c); cur_st = 2; cur_sen = 1'b1; expect_at(c, 0, 0);
    if ($urandom_range(1, 0) == 1) put_done(c + 2);   // not searching: ignored
    plan_fs(c); cur_st = 3; cur_sen = 1'b0; expect_at(c, 0, 0);
    plan_fs(c); cur_st = 4; expect_at(c, 1, 0);
  endtask

  // One search: n plain frame starts (timeouts every TMO), a result, then hold.
  task automatic plan_round();
    int  c, d, r, n, px, py;
    bit  coinc;
    coinc = ($urandom_range(3, 0) == 0);
    n = int'($urandom_range(17, 0));
    if (coinc && $urandom_range(1, 0) == 1) n = TMO - 1;   // done lands on would-be timeout
    for (int j = 1; j <= n; j++) begin
      plan_fs(c);
      if (j % TMO == 0) begin cur_fin = 1'b0; expect_at(c, 1, 1); end
    end
    if (coinc) begin plan_fs(c); d = c; end
    else d = t + int'($urandom_range(4, 1));
    put_done(d);
    px = clampv(dx_a[d], MX);
    py = clampv(dy_a[d], MY);
    cur_st = 5; expect_at(d, 0, 0);
    if ($urandom_range(4, 0) == 0) begin
      r = d + 2;
      sv_a[r] = 1'b1;
      cur_st = 1; cur_sen = 1'b0; cur_fin = 1'b0; expect_at(r, 0, 0);
      put_done(r + 2);                                     // after restart: ignored
      t = r + 2;
      plan_save_seq();
      return;
    end
    for (int h = 1; h <= REF; h++) begin
      plan_fs(c);
      if (h == 1) begin cur_x = px; cur_y = py; cur_fin = 1'b1; end
      if (h == REF) cur_st = 4;
      expect_at(c, h == REF, 0);
      if (h < REF && $urandom_range(1, 0) == 1) put_done(c + 3); // in HOLD: ignored
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: any pulse or change of the visible outputs is one event.
  bit p_sen = 0, p_ss = 0, p_fin = 0;
  int p_st = 0, p_x = 0, p_y = 0;
  always @(negedge clk) begin
    ev_t o, e;
    if (mon_en) begin
      o.cyc = cyc; o.st = int'(bus.oSTATE); o.sen = bus.oSAVE_EN; o.ss = bus.oSRCH_START;
      o.tmo = bus.oTIMEOUT; o.x = int'(bus.oXresult); o.y = int'(bus.oYresult); o.fin = bus.oFinished;
      if (o.ss) check("start_single_cycle", int'(p_ss), 0);
      if (o.ss || o.tmo || o.st != p_st || o.sen != p_sen || o.x != p_x || o.y != p_y || o.fin != p_fin) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got %s, expected no event", ev_s(o));
        end else begin
          e = exp_q.pop_front();
          if (ev_eq(o, e)) n_pass++;
          else $display("FAIL event: got %s, expected %s", ev_s(o), ev_s(e));
        end
      end
      p_st = o.st; p_sen = o.sen; p_ss = o.ss; p_x = o.x; p_y = o.y; p_fin = o.fin;
    end
  end

  initial begin
    int tend;
    rst_n = 1'b0;
    bus.iSAVE_REQ = 0; bus.iFRAME_START = 0; bus.iSRCH_DONE = 0;
    bus.iSRCH_X = '0; bus.iSRCH_Y = '0;
    repeat (3) tick();
    check("rst_state",   int'(bus.oSTATE), 0);
    check("rst_save_en", int'(bus.oSAVE_EN), 0);
    check("rst_start",   int'(bus.oSRCH_START), 0);
    check("rst_timeout", int'(bus.oTIMEOUT), 0);
    check("rst_x",       int'(bus.oXresult), 0);
    check("rst_y",       int'(bus.oYresult), 0);
    check("rst_fin",     int'(bus.oFinished), 0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Plan the whole run.
    t = cyc + 3;
    sv_a[t] = 1'b1;
    cur_st = 1; expect_at(t, 0, 0);
    plan_save_seq();
    for (int k = 0; k < 30 && t < MAXC - 1500; k++) plan_round();
    tend = t + 40;

    // Play it.
    while (cyc <= tend) begin
      bus.iFRAME_START = fs_a[cyc];
      bus.iSRCH_DONE   = dn_a[cyc];
      bus.iSAVE_REQ    = sv_a[cyc];
      bus.iSRCH_X      = dn_a[cyc] ? CW'(dx_a[cyc]) : CW'($urandom);
      bus.iSRCH_Y      = dn_a[cyc] ? CW'(dy_a[cyc]) : CW'($urandom);
      tick();
    end
    bus.iFRAME_START = 0; bus.iSRCH_DONE = 0; bus.iSAVE_REQ = 0;
    repeat (5) tick();
    check("events_outstanding", exp_q.size(), 0);
    mon_en = 1'b0;

    // Restart from SEARCH, enter SAVE, then reset mid-frame.
    bus.iSAVE_REQ = 1; tick(); bus.iSAVE_REQ = 0;
    check("restart_state", int'(bus.oSTATE), 1);
    repeat (3) tick();
    bus.iFRAME_START = 1; tick(); bus.iFRAME_START = 0;
    repeat (3) tick();
    check("save_state",   int'(bus.oSTATE), 2);
    check("save_en_high", int'(bus.oSAVE_EN), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_state",   int'(bus.oSTATE), 0);
    check("midrst_save_en", int'(bus.oSAVE_EN), 0);
    check("midrst_start",   int'(bus.oSRCH_START), 0);
    check("midrst_timeout", int'(bus.oTIMEOUT), 0);
    check("midrst_x",       int'(bus.oXresult), 0);
    check("midrst_y",       int'(bus.oYresult), 0);
    check("midrst_fin",     int'(bus.oFinished), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
